// File: rtl/mul_arb_if.sv
// Bundle of requester-side and multiplier-side signals around the shared multiplier arbiter.
// Latency: none, wires only.
// Backpressure: none here; requesters hold REQ until ACK, the multiplier answers with DONE.
interface mul_arb_if #(
  parameter int LEN  = 16,
  parameter int NREQ = 4
);
  // requester side
  logic [NREQ-1:0]     REQ;
  logic [NREQ*LEN-1:0] REQ_A;
  logic [NREQ*LEN-1:0] REQ_B;
  logic [NREQ-1:0]     ACK;
  logic [LEN-1:0]      RES_Y;
  logic                RES_ERR;
  logic                BUSY;
  // multiplier side
  logic                MUL_START;
  logic [LEN-1:0]      MUL_A;
  logic [LEN-1:0]      MUL_B;
  logic                MUL_DONE;
  logic [LEN-1:0]      MUL_Y;

  // arbiter view
  modport slave (
    input  REQ, REQ_A, REQ_B, MUL_DONE, MUL_Y,
    output ACK, RES_Y, RES_ERR, BUSY, MUL_START, MUL_A, MUL_B
  );

  // environment view: requesters plus the multiplier
  modport master (
    output REQ, REQ_A, REQ_B, MUL_DONE, MUL_Y,
    input  ACK, RES_Y, RES_ERR, BUSY, MUL_START, MUL_A, MUL_B
  );
endinterface

// File: rtl/mul_arb.sv
// Round-robin sequencer sharing one START/DONE multiplier among NREQ requesters.
// Latency: REQ at cycle k -> MUL_START at k+1 -> ACK at k+4 at best (DONE at k+3), k+22 on timeout.
// Backpressure: one operation in flight; other requesters simply hold REQ until granted.
module mul_arb #(
  parameter int LEN     = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 20
) (
  input  logic      CLK,
  input  logic      RST,
  mul_arb_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;       // last requester served
  logic [IW-1:0]   grant_q, grant_d;   // requester currently being served
  logic [LEN-1:0]  mul_a_q, mul_a_d;
  logic [LEN-1:0]  mul_b_q, mul_b_d;
  logic            start_q, start_d;
  logic [CW-1:0]   cnt_q, cnt_d;       // WAIT cycles elapsed
  logic [LEN-1:0]  res_y_q, res_y_d;
  logic            res_err_q, res_err_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [NREQ-1:0] grant_oh;

  // Round-robin search: first set REQ bit strictly after the last-served pointer, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!pick_vld && bus.REQ[idx]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  // One-hot form of the current grant, used for the ACK pulse.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Next-state logic; every output is computed here for the cycle after and registered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    cnt_d     = cnt_q;
    res_y_d   = '0;
    res_err_d = 1'b0;
    ack_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          // operands are captured only here; later changes by the requester are ignored
          grant_d = pick;
          mul_a_d = bus.REQ_A[pick*LEN +: LEN];
          mul_b_d = bus.REQ_B[pick*LEN +: LEN];
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // DONE in the first WAIT cycle may belong to an earlier or pre-reset operation
        if (cnt_q != '0 && bus.MUL_DONE) begin
          res_y_d   = bus.MUL_Y;
          res_err_d = 1'b0;
          ack_d     = grant_oh;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            res_y_d   = '0;
            res_err_d = 1'b1;
            ack_d     = grant_oh;
            state_d   = S_RESP;
          end
        end
      end

      S_RESP: begin
        ptr_d   = grant_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any in-flight operation silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(NREQ - 1);
      grant_q   <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      res_y_q   <= '0;
      res_err_q <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      res_y_q   <= res_y_d;
      res_err_q <= res_err_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ACK       = ack_q;
  assign bus.RES_Y     = res_y_q;
  assign bus.RES_ERR   = res_err_q;
  assign bus.BUSY      = busy_q;
  assign bus.MUL_START = start_q;
  assign bus.MUL_A     = mul_a_q;
  assign bus.MUL_B     = mul_b_q;

endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb with a behavioural START/DONE multiplier.
// Latency: checks exact cycle of START and ACK against hand-derived timing.
// Backpressure: requesters hold REQ until ACK; multiplier DONE forced high/low in some cases.
module tb_mul_arb;

  localparam int LEN     = 16;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 20;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mul_arb_if #(.LEN(LEN), .NREQ(NREQ)) bus ();

  mul_arb #(.LEN(LEN), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [NREQ-1:0]     req   = '0;
  logic [NREQ*LEN-1:0] req_a = '0;
  logic [NREQ*LEN-1:0] req_b = '0;
  assign bus.REQ   = req;
  assign bus.REQ_A = req_a;
  assign bus.REQ_B = req_b;

  // multiplier model: mode 0 = DONE mul_lat edges after START, 1 = DONE stuck high, 2 = stuck low
  int             mode    = 0;
  int             mul_lat = 2;
  int             mcnt    = 0;
  logic [LEN-1:0] myreg   = '0;
  always @(posedge CLK) begin
    if (bus.MUL_START) begin
      mcnt  <= mul_lat;
      myreg <= bus.MUL_A * bus.MUL_B;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign bus.MUL_DONE = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (mcnt == 1);
  assign bus.MUL_Y    = myreg;

  // background monitors
  int n_multi = 0;
  int n_start = 0;
  always @(negedge CLK) begin
    if (!$onehot0(bus.ACK)) n_multi <= n_multi + 1;
    if (bus.MUL_START)      n_start <= n_start + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    req_a[i*LEN +: LEN] = a;
    req_b[i*LEN +: LEN] = b;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // steps until an ACK is seen or the budget runs out; ack=0 on expiry
  task automatic wait_ack(input int maxc, output logic [NREQ-1:0] ack, output int cyc);
    ack = '0;
    cyc = 0;
    while (cyc < maxc) begin
      step();
      cyc++;
      if (bus.ACK != '0) begin
        ack = bus.ACK;
        break;
      end
    end
  endtask

  logic [NREQ-1:0] ack;
  int              cyc;
  int              s0;
  logic [3:0]      exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0]     exp_prod  [5] = '{16'd20, 16'd33, 16'd48, 16'd65, 16'd20};

  initial begin
    // ---- reset state and minimum-latency transaction
    set_op(0, 16'd3, 16'd5);
    do_reset();
    chk("rst_ack", bus.ACK, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_start", bus.MUL_START, 0);
    chk("rst_mul_a", bus.MUL_A, 0);
    chk("rst_mul_b", bus.MUL_B, 0);
    chk("rst_res_y", bus.RES_Y, 0);
    chk("rst_err", bus.RES_ERR, 0);
    req = 4'b0001;                       // cycle k
    step();                              // k+1
    chk("t1_start_k1", bus.MUL_START, 1);
    chk("t1_busy_k1", bus.BUSY, 1);
    chk("t1_mul_a", bus.MUL_A, 3);
    chk("t1_mul_b", bus.MUL_B, 5);
    step();                              // k+2
    chk("t1_start_k2", bus.MUL_START, 0);
    step();                              // k+3
    chk("t1_ack_k3", bus.ACK, 0);
    step();                              // k+4
    chk("t1_ack_k4", bus.ACK, 4'b0001);
    chk("t1_res_y", bus.RES_Y, 15);
    chk("t1_err", bus.RES_ERR, 0);
    req = '0;
    step();
    chk("t1_ack_off", bus.ACK, 0);
    chk("t1_res_off", bus.RES_Y, 0);
    chk("t1_busy_off", bus.BUSY, 0);

    // ---- slower multiplier, truncated products
    mul_lat = 5;
    set_op(2, 16'd193, 16'd1543);
    req = 4'b0100;
    wait_ack(20, ack, cyc);
    chk("t2_ack", ack, 4'b0100);
    chk("t2_res_y", bus.RES_Y, 16'h8B47);
    req = '0;
    step();
    set_op(2, 16'h0100, 16'h0100);
    req = 4'b0100;
    wait_ack(20, ack, cyc);
    chk("t2_ack_ovf", ack, 4'b0100);
    chk("t2_res_ovf", bus.RES_Y, 16'h0000);
    req = '0;
    step();
    mul_lat = 2;

    // ---- all requesters held from reset: round-robin order
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 2), 16'(i + 10));
    req = 4'b1111;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      wait_ack(30, ack, cyc);
      chk($sformatf("t3_order%0d", n), ack, exp_order[n]);
      chk($sformatf("t3_res%0d", n), bus.RES_Y, exp_prod[n]);
    end
    req = '0;
    step();
    step();

    // ---- DONE stuck high: first WAIT cycle ignored
    mode = 1;
    set_op(1, 16'd6, 16'd7);
    req = 4'b0010;                       // k
    step();
    step();
    step();                              // k+3
    chk("t4_ack_k3", bus.ACK, 0);
    step();                              // k+4
    chk("t4_ack_k4", bus.ACK, 4'b0010);
    chk("t4_res_y", bus.RES_Y, 42);
    req = '0;
    step();

    // ---- DONE stuck low: timeout after 20 WAIT cycles
    mode = 2;
    set_op(2, 16'd9, 16'd9);
    req = 4'b0100;                       // k
    wait_ack(40, ack, cyc);
    chk("t4_to_ack", ack, 4'b0100);
    chk("t4_to_cycles", cyc, 22);
    chk("t4_to_err", bus.RES_ERR, 1);
    chk("t4_to_res", bus.RES_Y, 0);
    req = '0;
    step();
    mode = 0;
    set_op(0, 16'd12, 16'd12);
    req = 4'b0001;
    wait_ack(20, ack, cyc);
    chk("t4_after_ack", ack, 4'b0001);
    chk("t4_after_res", bus.RES_Y, 144);
    chk("t4_after_err", bus.RES_ERR, 0);
    req = '0;
    step();

    // ---- reset in WAIT while serving requester 1 (pointer currently 0)
    set_op(0, 16'd4, 16'd6);
    set_op(1, 16'd7, 16'd9);
    req = 4'b0010;                       // k
    step();                              // k+1 ISSUE
    step();                              // k+2 WAIT
    RST = 1'b1;
    step();                              // k+3
    chk("t5_ack_after_rst", bus.ACK, 0);
    chk("t5_busy_after_rst", bus.BUSY, 0);
    RST = 1'b0;
    req = 4'b0011;
    step();
    chk("t5_start", bus.MUL_START, 1);
    chk("t5_grant0_a", bus.MUL_A, 4);
    wait_ack(20, ack, cyc);
    chk("t5_ack0", ack, 4'b0001);
    chk("t5_res0", bus.RES_Y, 24);
    req = 4'b0010;
    wait_ack(20, ack, cyc);
    chk("t5_ack1", ack, 4'b0010);
    chk("t5_res1", bus.RES_Y, 63);
    req = '0;
    step();

    // ---- requester 3 drops REQ right after grant
    s0 = n_start;
    set_op(3, 16'd11, 16'd13);
    req = 4'b1000;                       // k
    step();                              // k+1
    req = '0;
    wait_ack(20, ack, cyc);
    chk("t6_ack", ack, 4'b1000);
    chk("t6_res", bus.RES_Y, 143);
    step();
    step();
    step();
    chk("t6_one_start", n_start - s0, 1);
    chk("t6_idle", bus.BUSY, 0);

    chk("ack_onehot", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Round-robin arbiter/sequencer sharing one sequential multiplier (START/DONE, A/B/Y, LEN-bit) among NREQ requesters.
- Latches the winner's operands, pulses the multiplier START, waits for DONE with a timeout, and returns the product to the winner with a one-cycle ACK.
- Sits between client blocks and the single multiplier instance; the multiplier itself has no reset.

Parameters:
- LEN, 16, operand/result width (matches multiplier LEN).
- NREQ, 4, number of requesters, 2..16.
- TIMEOUT, 20, max WAIT cycles before abort, >=2.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  per-requester request level.
- REQ_A  in  NREQ*LEN  operand A, slice i = bits [i*LEN +: LEN].
- REQ_B  in  NREQ*LEN  operand B, same slicing.
- ACK  out  NREQ  one-hot, one-cycle completion pulse.
- RES_Y  out  LEN  result, valid only while any ACK bit is high.
- RES_ERR  out  1  timeout flag, valid with ACK.
- BUSY  out  1  high in every state except IDLE.
- MUL_START  out  1  to multiplier START.
- MUL_A  out  LEN  to multiplier A.
- MUL_B  out  LEN  to multiplier B.
- MUL_DONE  in  1  from multiplier DONE.
- MUL_Y  in  LEN  from multiplier Y.

Behaviour:
- Reset (RST high at an edge):
  - state=IDLE; last-served pointer=NREQ-1, so requester 0 has top priority first.
  - ACK=0, RES_Y=0, RES_ERR=0, BUSY=0, MUL_START=0, MUL_A=0, MUL_B=0, wait counter=0.
  - Reset mid-operation aborts it: no ACK is issued and the in-flight result is discarded.
- IDLE:
  - If any REQ is high, grant the first set bit searching from pointer+1 upward with wrap-around.
  - Latch the grant index and that requester's A/B into the MUL_A/MUL_B registers, then go to ISSUE.
  - If no REQ is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - MUL_START=1.
  - Go to WAIT with wait counter=0.
- WAIT:
  - MUL_START=0; MUL_A/MUL_B held at the latched values.
  - MUL_DONE is ignored in the first WAIT cycle, because it may reflect the previous or pre-reset operation.
  - From the second WAIT cycle on: if MUL_DONE=1, latch MUL_Y into the result register, set err=0, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT, set result=0, err=1, go to RESP.
- RESP (exactly 1 cycle):
  - ACK[grant]=1, RES_Y=result, RES_ERR=err.
  - Pointer=grant; go to IDLE.
- Outside RESP: ACK=0, RES_Y=0, RES_ERR=0.
- Minimum latency: REQ seen in IDLE at cycle k gives MUL_START at k+1 and, with DONE at k+3, ACK at k+4.
- Requester rules:
  - Hold REQ and operands stable until ACK. Operands are sampled only in the grant cycle, so later changes are ignored.
  - A REQ deasserted while granted does not cancel the operation; the ACK still pulses and may be ignored.
  - REQ still high in the cycle after ACK counts as a new request. The requester is then arbitrated normally and has lowest priority.
- Arithmetic: RES_Y is MUL_Y passed through unchanged; the low LEN bits of A*B come from the multiplier.
- Only one operation is ever in flight. MUL_START is never asserted outside ISSUE.

Test Plan:
- Reset, then REQ[0] with A=3, B=5, multiplier DONE at k+3 -> ACK=4'b0001 at k+4, RES_Y=15, RES_ERR=0, MUL_START high only at k+1.
- REQ[2] with A=193, B=1543 against the real multiplier (LEN=16) -> ACK[2] within 20 cycles, RES_Y=0x8B47; also A=B=0x0100 -> RES_Y=0x0000.
- All four REQ held high from reset, distinct operands -> ACK order 0,1,2,3,0, each RES_Y the correct product, never two ACK bits high at once.
- Model holds MUL_DONE=1 permanently -> DONE in the first WAIT cycle is ignored, ACK arrives one cycle later; model holds MUL_DONE=0 -> ACK after TIMEOUT=20 WAIT cycles with RES_ERR=1, RES_Y=0, and the next request is served normally.
- RST asserted in WAIT while serving REQ[1] -> no ACK, BUSY=0 the next cycle, pointer reset so a simultaneous REQ[0] and REQ[1] grants 0 first.
- REQ[3] dropped after grant -> operation completes, ACK[3] still pulses, no second MUL_START.
